// File: rtl/config_pkg.sv
// Core configuration record handed down to CV-X-IF side blocks.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
   } cva6_cfg_t;

   // All-zero configuration: fields left at 0 mean "not constrained".
   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cvxif_pkg.sv
// CV-X-IF shared types: coprocessor result payload.
package cvxif_pkg;

   localparam int unsigned X_ID_W   = 4;
   localparam int unsigned X_RFW_W  = 32;
   localparam int unsigned X_EXCC_W = 6;

   typedef struct packed {
      logic [X_ID_W-1:0]   id;
      logic [X_RFW_W-1:0]  data;
      logic                we;
      logic                exc;
      logic [X_EXCC_W-1:0] exccode;
   } x_result_t;

endpackage

// File: rtl/cvxif_sync_fifo.sv
// Small result FIFO with synchronous active-high reset. Full/empty come
// from the occupancy counter so the pointers can wrap naturally.
module cvxif_sync_fifo
   import cvxif_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  x_result_t        data_i,
   input  logic             pop_i,
   output x_result_t        data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   x_result_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;

   // Storage write; contents are don't-care until counted, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wptr_q] <= data_i;
      end
   end

   // Pointers and occupancy; push/pop in the same cycle leaves count alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + PTR_W'(1);
         if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
         if (push_i && !pop_i) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop_i && !push_i) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/cvxif_result_buffer.sv
// Result-side buffer between the CV-X-IF response channel and cvxif_fu.
// Buffers coprocessor results, lets writeback stall, and hands out issue
// credits so that a result always finds a free FIFO slot.
module cvxif_result_buffer
   import cvxif_pkg::*;
#(
   parameter  config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_fire_i,
   output logic             credit_avail_o,
   input  logic             cp_result_valid_i,
   output logic             cp_result_ready_o,
   input  x_result_t        cp_result_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output x_result_t        wb_result_o,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] outstanding_o,
   output logic             err_o
);

   // Reject configurations the pointer/count scheme cannot handle.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("cvxif_result_buffer: DEPTH must be a power of 2 and >= 2");
   end
   if (CVA6Cfg.XLEN != 0 && CVA6Cfg.XLEN < X_RFW_W) begin : g_xlen_chk
      $error("cvxif_result_buffer: coprocessor data wider than XLEN");
   end

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   x_result_t        head;
   logic [CNT_W-1:0] outstanding_q;
   logic             err_q;

   // Ready depends only on registered state; no path from wb_ready_i.
   assign push = cp_result_valid_i & ~full;
   assign pop  = ~empty & wb_ready_i;

   cvxif_sync_fifo #(
      .DEPTH (DEPTH)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (cp_result_i),
      .pop_i   (pop),
      .data_o  (head),
      .count_o (count_o),
      .full_o  (full),
      .empty_o (empty)
   );

   // Outstanding tracker: saturates at both ends and flags the sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else if (issue_fire_i && !pop) begin
         if (outstanding_q == CNT_W'(DEPTH)) begin
            err_q <= 1'b1;
         end else begin
            outstanding_q <= outstanding_q + CNT_W'(1);
         end
      end else if (pop && !issue_fire_i) begin
         if (outstanding_q == '0) begin
            err_q <= 1'b1;
         end else begin
            outstanding_q <= outstanding_q - CNT_W'(1);
         end
      end
   end

   assign credit_avail_o    = (outstanding_q < CNT_W'(DEPTH));
   assign cp_result_ready_o = ~full;
   assign wb_valid_o        = ~empty;
   assign wb_result_o       = empty ? '0 : head;
   assign outstanding_o     = outstanding_q;
   assign err_o             = err_q;

endmodule

// File: doc/cvxif_result_buffer.md
# cvxif_result_buffer

Result-side buffer between the CV-X-IF coprocessor response channel and `cvxif_fu`. It registers coprocessor results into a small FIFO and presents them to the FU/writeback with valid/ready flow control, so writeback is free to stall. It also tracks the offloaded instructions that are still outstanding and grants issue credits, so the FIFO can never overflow.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration, passed through.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the occupancy and outstanding counters; derived, not overridable.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset, synchronous and active-high.
- `issue_fire_i`  in  1  pulse: coprocessor accepted an offloaded instruction (issue valid & ready & accept).
- `credit_avail_o`  out  1  issue may offload another instruction; `outstanding < DEPTH`.
- `cp_result_valid_i`  in  1  coprocessor result valid.
- `cp_result_ready_o`  out  1  buffer can accept a result; equals `!full`.
- `cp_result_i`  in  `cvxif_pkg::x_result_t`  result payload: id, data, we, exc, exccode.
- `wb_valid_o`  out  1  head entry valid; equals `!empty`.
- `wb_ready_i`  in  1  FU/writeback consumes the head entry.
- `wb_result_o`  out  `cvxif_pkg::x_result_t`  head entry; `'0` when empty.
- `count_o`  out  CNT_W  FIFO occupancy.
- `outstanding_o`  out  CNT_W  instructions issued but not yet popped at writeback.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Push:** `cp_result_valid_i & cp_result_ready_o` writes `cp_result_i` at the write pointer.
- **Pop:** `wb_valid_o & wb_ready_i` advances the read pointer.
- **Simultaneous push and pop:** allowed when neither empty nor full; occupancy is unchanged.
- **Full:** `cp_result_ready_o=0` even if a pop happens the same cycle. There is no combinational ready path from `wb_ready_i`.
- **Empty:** no bypass. A result pushed into an empty FIFO appears at `wb_valid_o` the next cycle.
- **Pointers:** `$clog2(DEPTH)` bits, wrapping naturally. Full and empty are derived from `count`, not from pointer equality.
- **Outstanding counter:** +1 on `issue_fire_i`, -1 on pop; both in the same cycle means no change.
- **Overflow:** `issue_fire_i` while `outstanding==DEPTH` saturates the counter and sets `err_o`.
- **Underflow:** a pop while `outstanding==0` holds the counter at 0 and sets `err_o`. This is a result without a matching issue.
- **Invariant:** `count <= outstanding`. When credits are honoured, the FIFO never refuses a result.
- **`err_o`:** cleared only by `rst_i`.
- **Ordering:** results leave in coprocessor delivery order. IDs are not reordered or checked.

## Timing
- Reset state, taken on any `rst_i` edge including mid-operation:
  - pointers, `count`, `outstanding` = 0; `err_o=0`;
  - `wb_valid_o=0`, `wb_result_o='0`, `cp_result_ready_o=1`, `credit_avail_o=1`.
  - Buffered entries are discarded, and the memory contents need no reset.
- Latency: push at edge N gives `wb_valid_o=1` after edge N, so the entry can be consumed in cycle N+1.
- Throughput: one push and one pop per cycle.
- `credit_avail_o` updates the cycle after `issue_fire_i`/pop. Issue must sample it before firing.
- All outputs are driven from registers, or from registers plus the FIFO read mux. No input-to-output combinational path exists.

## Structure
- `cvxif_pkg` owns `x_result_t`. No new package types; `CNT_W` is a local parameter.
- One sub-module, `cvxif_sync_fifo`: storage, pointers and count, with synchronous active-high reset. `fifo_v3` is not used because its reset is asynchronous.
- Top level holds the outstanding/credit counter, the error flag and output gating.

## Test plan
- **Single result:** reset, then `issue_fire_i` once, then push id=3 data=0xDEAD_BEEF we=1 with `wb_ready_i=1` → `wb_valid_o` one cycle after the push with id 3. Afterwards `outstanding_o`=0, `count_o`=0 and `credit_avail_o`=1.
- **Fill to full:** DEPTH=4, fire 4 issues, push 4 results with `wb_ready_i=0` → `count_o`=4, `cp_result_ready_o`=0, `credit_avail_o`=0. Drain 4 → ids come out in push order, then empty with `wb_result_o='0`.
- **Streaming:** continuous issue, push and pop with `wb_ready_i=1` → 1 result/cycle, `count_o` steady at 1, 20 results in order, `err_o`=0.
- **Overflow:** a 5th `issue_fire_i` at `outstanding`=4 → `outstanding_o` stays 4 and `err_o`=1 next cycle, held until reset.
- **Underflow:** push and pop a result with no prior issue → `outstanding_o` stays 0 and `err_o`=1.
- **Reset mid-operation:** assert `rst_i` one cycle with `count`=3 and `outstanding`=4 → next cycle all counters are 0, `wb_valid_o`=0, `cp_result_ready_o`=1, and stale entries never appear.
